frame_scanout_flip: RTL and testbench

- Display-side stage directly downstream of the renderer.
- Generates VGA-style raster timing and drives the renderer's vsync input.
- Owns front/back frame-buffer selection and swaps the buffers at the start of vertical blank once the renderer reports a finished frame.
- Pulses flip back to the renderer and produces the aligned scanout address for the frame-buffer read port.

---
 rtl/display_pkg.sv | 29 ++
 rtl/raster_timing.sv | 110 +++++++++++
 rtl/frame_scanout_flip.sv | 132 +++++++++++++
 tb/tb_frame_scanout_flip.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display timing defaults, frame-buffer bases and flip FSM state type.
package display_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int CLK_DIV  = 4;
   localparam int ADDR_W   = 32;

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Raster counters and pix_x/pix_y share this width.
   localparam int CNT_W    = 10;

   localparam logic [ADDR_W-1:0] FB_BASE0 = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] FB_BASE1 = 32'h0004_B000;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } flip_state_t;

endpackage

// File: rtl/raster_timing.sv
// Pixel tick divider, h/v raster counters and registered sync/de decode.
module raster_timing
   import display_pkg::*;
#(
   parameter int P_H_ACTIVE = display_pkg::H_ACTIVE,
   parameter int P_H_FP     = display_pkg::H_FP,
   parameter int P_H_SYNC   = display_pkg::H_SYNC,
   parameter int P_H_BP     = display_pkg::H_BP,
   parameter int P_V_ACTIVE = display_pkg::V_ACTIVE,
   parameter int P_V_FP     = display_pkg::V_FP,
   parameter int P_V_SYNC   = display_pkg::V_SYNC,
   parameter int P_V_BP     = display_pkg::V_BP,
   parameter int P_CLK_DIV  = display_pkg::CLK_DIV
) (
   input  logic             clk,
   input  logic             resetn,
   output logic             h_wrap,
   output logic             v_wrap,
   output logic             vblank_start,
   output logic [CNT_W-1:0] h,
   output logic             de,
   output logic             hsync_n,
   output logic             vsync_n,
   output logic             vsync,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y
);

   localparam int TICK_W = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
   localparam int H_TOT  = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
   localparam int V_TOT  = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(P_CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0]  H_VIS     = CNT_W'(P_H_ACTIVE);
   localparam logic [CNT_W-1:0]  V_VIS     = CNT_W'(P_V_ACTIVE);
   localparam logic [CNT_W-1:0]  HS_BEG    = CNT_W'(P_H_ACTIVE + P_H_FP);
   localparam logic [CNT_W-1:0]  HS_END    = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
   localparam logic [CNT_W-1:0]  VS_BEG    = CNT_W'(P_V_ACTIVE + P_V_FP);
   localparam logic [CNT_W-1:0]  VS_END    = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
   logic              de_q, de_d, hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
   logic              vsync_q, vsync_d;
   logic [CNT_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic              tick;

   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

      h_d = h_q;
      v_d = v_q;
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end

      h_wrap       = tick && (h_q == H_LAST);
      v_wrap       = h_wrap && (v_q == V_LAST);
      vblank_start = h_wrap && (v_q == V_VIS - 1'b1);

      // Decode reflects the current counter state; it lands one clk later.
      de_d      = (h_q < H_VIS) && (v_q < V_VIS);
      hsync_n_d = !((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_n_d = !((v_q >= VS_BEG) && (v_q < VS_END));
      vsync_d   = (v_q >= V_VIS);
      pix_x_d   = de_d ? h_q : '0;
      pix_y_d   = de_d ? v_q : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_cnt_q <= '0;
         h_q        <= '0;
         v_q        <= '0;
         de_q       <= 1'b0;
         hsync_n_q  <= 1'b1;
         vsync_n_q  <= 1'b1;
         vsync_q    <= 1'b0;
         pix_x_q    <= '0;
         pix_y_q    <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         h_q        <= h_d;
         v_q        <= v_d;
         de_q       <= de_d;
         hsync_n_q  <= hsync_n_d;
         vsync_n_q  <= vsync_n_d;
         vsync_q    <= vsync_d;
         pix_x_q    <= pix_x_d;
         pix_y_q    <= pix_y_d;
      end
   end

   assign h       = h_q;
   assign de      = de_q;
   assign hsync_n = hsync_n_q;
   assign vsync_n = vsync_n_q;
   assign vsync   = vsync_q;
   assign pix_x   = pix_x_q;
   assign pix_y   = pix_y_q;

endmodule

// File: rtl/frame_scanout_flip.sv
// Scanout stage: raster timing, front/back buffer flip at vblank, scan address.
//   state   | meaning
//   IDLE    | no finished back buffer waiting
//   PENDING | back buffer finished, swap at next vblank start
module frame_scanout_flip
   import display_pkg::*;
#(
   parameter int                H_ACTIVE = display_pkg::H_ACTIVE,
   parameter int                H_FP     = display_pkg::H_FP,
   parameter int                H_SYNC   = display_pkg::H_SYNC,
   parameter int                H_BP     = display_pkg::H_BP,
   parameter int                V_ACTIVE = display_pkg::V_ACTIVE,
   parameter int                V_FP     = display_pkg::V_FP,
   parameter int                V_SYNC   = display_pkg::V_SYNC,
   parameter int                V_BP     = display_pkg::V_BP,
   parameter int                CLK_DIV  = display_pkg::CLK_DIV,
   parameter int                ADDR_W   = display_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] FB_BASE0 = display_pkg::FB_BASE0,
   parameter logic [ADDR_W-1:0] FB_BASE1 = display_pkg::FB_BASE1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              frame_done,
   output logic              vsync,
   output logic              flip,
   output logic [ADDR_W-1:0] back_base,
   output logic              hsync_n,
   output logic              vsync_n,
   output logic              de,
   output logic [ADDR_W-1:0] scan_addr,
   output logic [9:0]        pix_x,
   output logic [9:0]        pix_y,
   output logic [7:0]        dropped
);

   logic             h_wrap, v_wrap, vblank_start;
   logic [CNT_W-1:0] h;

   raster_timing #(
      .P_H_ACTIVE (H_ACTIVE),
      .P_H_FP     (H_FP),
      .P_H_SYNC   (H_SYNC),
      .P_H_BP     (H_BP),
      .P_V_ACTIVE (V_ACTIVE),
      .P_V_FP     (V_FP),
      .P_V_SYNC   (V_SYNC),
      .P_V_BP     (V_BP),
      .P_CLK_DIV  (CLK_DIV)
   ) u_raster_timing (
      .clk          (clk),
      .resetn       (resetn),
      .h_wrap       (h_wrap),
      .v_wrap       (v_wrap),
      .vblank_start (vblank_start),
      .h            (h),
      .de           (de),
      .hsync_n      (hsync_n),
      .vsync_n      (vsync_n),
      .vsync        (vsync),
      .pix_x        (pix_x),
      .pix_y        (pix_y)
   );

   flip_state_t       state_q, state_d;
   logic              front_sel_q, front_sel_d;
   logic              flip_q, flip_d;
   logic [7:0]        dropped_q, dropped_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
   logic              do_swap;

   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      flip_d      = 1'b0;
      dropped_d   = dropped_q;
      line_base_d = line_base_q;
      do_swap     = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_done) begin
               if (vblank_start) do_swap = 1'b1;
               else              state_d = PENDING;
            end
         end
         PENDING: begin
            // A pulse landing on the swap tick is for the buffer just handed over.
            if (vblank_start) begin
               do_swap = 1'b1;
               if (!frame_done) state_d = IDLE;
            end
            if (frame_done && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase

      if (do_swap) begin
         front_sel_d = ~front_sel_q;
         flip_d      = 1'b1;
      end

      if (v_wrap)      line_base_d = front_sel_d ? FB_BASE1 : FB_BASE0;
      else if (h_wrap) line_base_d = line_base_q + ADDR_W'(H_ACTIVE);

      scan_addr_d = line_base_q + ADDR_W'(h);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         front_sel_q <= 1'b0;
         flip_q      <= 1'b0;
         dropped_q   <= '0;
         line_base_q <= FB_BASE0;
         scan_addr_q <= FB_BASE0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         flip_q      <= flip_d;
         dropped_q   <= dropped_d;
         line_base_q <= line_base_d;
         scan_addr_q <= scan_addr_d;
      end
   end

   assign flip      = flip_q;
   assign dropped   = dropped_q;
   assign scan_addr = scan_addr_q;
   assign back_base = front_sel_q ? FB_BASE0 : FB_BASE1;

endmodule

// File: tb/tb_frame_scanout_flip.sv
// Directed bench for frame_scanout_flip on a tiny 12x7 raster (84 clks/frame).
module tb_frame_scanout_flip;

   localparam int          HA = 8, HF = 1, HS = 2, HB = 1;
   localparam int          VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int          HT = HA + HF + HS + HB;
   localparam int          VT = VA + VF + VS + VB;
   localparam logic [31:0] B0 = 32'h0;
   localparam logic [31:0] B1 = 32'h100;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        frame_done = 1'b0;
   logic        vsync, flip, hsync_n, vsync_n, de;
   logic [31:0] back_base, scan_addr;
   logic [9:0]  pix_x, pix_y;
   logic [7:0]  dropped;

   frame_scanout_flip #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .CLK_DIV  (1),  .ADDR_W (32), .FB_BASE0 (B0), .FB_BASE1 (B1)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .frame_done (frame_done),
      .vsync      (vsync),
      .flip       (flip),
      .back_base  (back_base),
      .hsync_n    (hsync_n),
      .vsync_n    (vsync_n),
      .de         (de),
      .scan_addr  (scan_addr),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        de, hs_n, vs_n, vsync, flip;
      logic [31:0] addr, back;
      logic [9:0]  px, py;
      logic [7:0]  drop;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          mh, mv, mdrop;
   logic        mfs, mpend;
   logic [31:0] mframe_base;
   int          cnt_de, cnt_vsync, cnt_vsn, cnt_hsn, cnt_flip;
   logic [31:0] first_addr;
   logic        seen_de;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mh = 0; mv = 0; mdrop = 0; mfs = 1'b0; mpend = 1'b0; mframe_base = B0;
   endtask

   task automatic clear_counts();
      cnt_de = 0; cnt_vsync = 0; cnt_vsn = 0; cnt_hsn = 0; cnt_flip = 0; seen_de = 1'b0;
      first_addr = '0;
   endtask

   task automatic chk_reset_values();
      chk("rst_de", 32'(de), 32'd0);
      chk("rst_hsync_n", 32'(hsync_n), 32'd1);
      chk("rst_vsync_n", 32'(vsync_n), 32'd1);
      chk("rst_vsync", 32'(vsync), 32'd0);
      chk("rst_flip", 32'(flip), 32'd0);
      chk("rst_scan_addr", scan_addr, B0);
      chk("rst_back_base", back_base, B1);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
      chk("rst_dropped", 32'(dropped), 32'd0);
   endtask

   // One clk: drive frame_done, push the expectation, then compare after the edge.
   task automatic step(input logic fd);
      exp_t e;
      exp_t got;
      logic swap;
      frame_done = fd;
      e.de    = (mh < HA) && (mv < VA);
      e.hs_n  = !((mh >= HA + HF) && (mh < HA + HF + HS));
      e.vs_n  = !((mv >= VA + VF) && (mv < VA + VF + VS));
      e.vsync = (mv >= VA);
      e.addr  = mframe_base + 32'(mv * HA) + 32'(mh);
      e.px    = e.de ? 10'(mh) : 10'd0;
      e.py    = e.de ? 10'(mv) : 10'd0;
      swap    = (mh == HT - 1) && (mv == VA - 1);
      e.flip  = swap && (mpend || fd);
      if (mpend && fd && mdrop < 255) mdrop++;
      if (e.flip) mfs = ~mfs;
      mpend = mpend ? !(swap && !fd) : (fd && !swap);
      if (mh == HT - 1) begin
         mh = 0;
         if (mv == VT - 1) begin
            mv = 0;
            mframe_base = mfs ? B1 : B0;
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
      e.back = mfs ? B0 : B1;
      e.drop = 8'(mdrop);
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      chk("de", 32'(de), 32'(got.de));
      chk("hsync_n", 32'(hsync_n), 32'(got.hs_n));
      chk("vsync_n", 32'(vsync_n), 32'(got.vs_n));
      chk("vsync", 32'(vsync), 32'(got.vsync));
      chk("flip", 32'(flip), 32'(got.flip));
      chk("scan_addr", scan_addr, got.addr);
      chk("back_base", back_base, got.back);
      chk("pix_x", 32'(pix_x), 32'(got.px));
      chk("pix_y", 32'(pix_y), 32'(got.py));
      chk("dropped", 32'(dropped), 32'(got.drop));
      cnt_de    += 32'(de);
      cnt_vsync += 32'(vsync);
      cnt_vsn   += 32'(!vsync_n);
      cnt_hsn   += 32'(!hsync_n);
      cnt_flip  += 32'(flip);
      if (de && !seen_de) begin
         seen_de    = 1'b1;
         first_addr = scan_addr;
      end
      frame_done = 1'b0;
   endtask

   initial begin
      model_reset();
      clear_counts();
      #12;
      chk_reset_values();
      @(posedge clk);
      #2 resetn = 1'b1;

      // Plain frame timing.
      clear_counts();
      repeat (84) step(1'b0);
      chk("frame_de_clks", 32'(cnt_de), 32'd32);
      chk("frame_vsync_clks", 32'(cnt_vsync), 32'd36);
      chk("frame_vsync_n_low", 32'(cnt_vsn), 32'd12);
      chk("frame_hsync_n_low", 32'(cnt_hsn), 32'd14);
      chk("frame_no_flip", 32'(cnt_flip), 32'd0);
      chk("frame_first_addr", first_addr, B0);

      // Single frame_done -> one flip, next frame reads buffer 1.
      clear_counts();
      for (int i = 0; i < 84; i++) step(i == 10);
      chk("flip_once", 32'(cnt_flip), 32'd1);
      chk("flip_back_base", back_base, B0);
      clear_counts();
      repeat (84) step(1'b0);
      chk("after_flip_first_addr", first_addr, B1);
      chk("after_flip_no_flip", 32'(cnt_flip), 32'd0);

      // Idle frames: no flips, no drops.
      clear_counts();
      repeat (3 * 84) step(1'b0);
      chk("idle_no_flip", 32'(cnt_flip), 32'd0);
      chk("idle_dropped", 32'(dropped), 32'd0);
      chk("idle_de_clks", 32'(cnt_de), 32'd96);

      // Two pulses in one frame, then saturation.
      clear_counts();
      for (int i = 0; i < 84; i++) step((i == 5) || (i == 20));
      chk("double_single_flip", 32'(cnt_flip), 32'd1);
      chk("double_dropped", 32'(dropped), 32'd1);
      repeat (300) step(1'b1);
      repeat (84) step(1'b0);
      chk("dropped_saturated", 32'(dropped), 32'd255);

      // frame_done coincident with the swap tick while idle.
      for (int i = 0; i < 200 && !((mh == HT - 1) && (mv == VA - 1)); i++) step(1'b0);
      clear_counts();
      step(1'b1);
      chk("bypass_flip_now", 32'(cnt_flip), 32'd1);
      clear_counts();
      repeat (84) step(1'b0);
      chk("bypass_no_second_flip", 32'(cnt_flip), 32'd0);

      // Reset while a flip is pending discards it.
      for (int i = 0; i < 200 && !((mh == 0) && (mv == 0)); i++) step(1'b0);
      for (int i = 0; i < 40; i++) step(i == 10);
      resetn = 1'b0;
      #1;
      chk_reset_values();
      @(posedge clk);
      @(posedge clk);
      #2 resetn = 1'b1;
      model_reset();
      clear_counts();
      repeat (84) step(1'b0);
      chk("post_reset_no_flip", 32'(cnt_flip), 32'd0);
      chk("post_reset_back_base", back_base, B1);
      chk("post_reset_first_addr", first_addr, B0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
